// File: rtl/note_sprite_drawer.sv
// Falling 64x64 note sprite for one lane: frame-stepped position, sprite RAM
// addressing, and a two-clock pixel pipeline aligned to the scan position.
//
// state | meaning
// IDLE  | no note on screen, waiting for spawn
// FALL  | note moves down speed_reg rows per frame until hit or miss
// HIT   | note frozen and drawn inverted for HIT_FRAMES frames
module note_sprite_drawer #(
  parameter logic [9:0]  LANE_X     = 10'd160,
  parameter logic [9:0]  MISS_Y     = 10'd440,
  parameter logic [23:0] KEY_RGB    = 24'hFF00FF,
  parameter logic [3:0]  HIT_FRAMES = 4'd8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        spawn,
  input  logic [3:0]  speed,
  input  logic        hit,
  input  logic [23:0] rom_data,
  output logic [12:0] read_address,
  output logic        pixel_on,
  output logic [23:0] pixel_rgb,
  output logic        active,
  output logic [9:0]  note_y,
  output logic        missed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    HIT  = 2'd2
  } state_t;

  localparam logic [10:0] X_HI = {1'b0, LANE_X} + 11'd63;

  state_t      state, state_n;
  logic [9:0]  note_y_n;
  logic [3:0]  speed_reg, speed_n;
  logic [3:0]  flash_cnt, flash_n;
  logic        missed_n;
  logic        frame_q;
  logic        frame_edge;
  logic [10:0] y_sum;
  logic [10:0] y_hi;
  logic        inbox;
  logic [5:0]  dx, dy;
  logic        inbox_d1, flash_d1, inbox_d2, flash_d2;

  assign frame_edge = frame_clk && !frame_q;
  assign y_sum      = {1'b0, note_y} + {7'd0, speed_reg};
  assign y_hi       = {1'b0, note_y} + 11'd63;

  always_comb begin
    state_n  = state;
    note_y_n = note_y;
    speed_n  = speed_reg;
    flash_n  = flash_cnt;
    missed_n = 1'b0;
    case (state)
      IDLE: begin
        if (spawn) begin
          state_n  = FALL;
          note_y_n = 10'd0;
          speed_n  = (speed == 4'd0) ? 4'd1 : speed;
        end
      end
      FALL: begin
        // A hit freezes the note even when a frame edge lands in the same cycle.
        if (hit) begin
          state_n = HIT;
          flash_n = HIT_FRAMES;
        end else if (frame_edge) begin
          if (y_sum >= {1'b0, MISS_Y}) begin
            state_n  = IDLE;
            note_y_n = 10'd0;
            missed_n = 1'b1;
          end else begin
            note_y_n = y_sum[9:0];
          end
        end
      end
      HIT: begin
        if (frame_edge) begin
          flash_n = flash_cnt - 4'd1;
          if (flash_cnt == 4'd1) begin
            state_n  = IDLE;
            note_y_n = 10'd0;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        note_y_n = 10'd0;
      end
    endcase
  end

  // Low six bits of the offsets suffice: the box is exactly 64 wide and tall.
  assign dx = DrawX[5:0] - LANE_X[5:0];
  assign dy = DrawY[5:0] - note_y[5:0];

  assign inbox = (state != IDLE) &&
                 (DrawX >= LANE_X) && ({1'b0, DrawX} <= X_HI) &&
                 (DrawY >= note_y) && ({1'b0, DrawY} <= y_hi);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      note_y       <= 10'd0;
      speed_reg    <= 4'd1;
      flash_cnt    <= 4'd0;
      missed       <= 1'b0;
      frame_q      <= 1'b0;
      read_address <= 13'd0;
      inbox_d1     <= 1'b0;
      flash_d1     <= 1'b0;
      inbox_d2     <= 1'b0;
      flash_d2     <= 1'b0;
    end else begin
      state        <= state_n;
      note_y       <= note_y_n;
      speed_reg    <= speed_n;
      flash_cnt    <= flash_n;
      missed       <= missed_n;
      frame_q      <= frame_clk;
      read_address <= inbox ? {1'b0, dy, dx} : 13'd0;
      inbox_d1     <= inbox;
      flash_d1     <= (state == HIT);
      inbox_d2     <= inbox_d1;
      flash_d2     <= flash_d1;
    end
  end

  assign active    = (state == FALL) || (state == HIT);
  assign pixel_on  = inbox_d2 && (rom_data != KEY_RGB);
  assign pixel_rgb = pixel_on ? (flash_d2 ? ~rom_data : rom_data) : 24'h0;

endmodule
